// File: rtl/fcc_mac_neuron_pkg.sv
// Shared types and constant helpers for the FCC multiply-accumulate neuron.
// Holds the controller state encoding, accumulator sizing rule and saturation bounds.
package fcc_pkg;

   typedef enum logic [1:0] {
      ACC = 2'd0,
      FIN = 2'd1,
      OUT = 2'd2
   } fcc_state_e;

   // Smallest accumulator that cannot wrap for n_in full-scale products.
   function automatic int min_acc_w(input int data_w, input int n_in);
      return 2 * data_w + $clog2(n_in);
   endfunction

   function automatic longint sat_max(input int out_w);
      return (64'sd1 <<< (out_w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int out_w);
      return -(64'sd1 <<< (out_w - 1));
   endfunction

endpackage

// File: rtl/fcc_mac_neuron_if.sv
// Node/weight input stream and result output stream of one MAC neuron.
// The slave modport is the neuron side, the master modport is the producer/consumer side.
interface fcc_mac_neuron_if #(
   parameter int DATA_W = 8,
   parameter int OUT_W  = 16
);

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_node;
   logic signed [DATA_W-1:0] in_wegt;
   logic signed [DATA_W-1:0] in_bias;
   logic                     in_last;

   logic                     out_valid;
   logic                     out_ready;
   logic signed [OUT_W-1:0]  out_data;
   logic                     out_sat;
   logic                     out_len_err;

   modport slave (
      input  in_valid, in_node, in_wegt, in_bias, in_last, out_ready,
      output in_ready, out_valid, out_data, out_sat, out_len_err
   );

   modport master (
      output in_valid, in_node, in_wegt, in_bias, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_sat, out_len_err
   );

endinterface

// File: rtl/fcc_mac_neuron_sat_relu.sv
// Optional ReLU followed by signed saturation of a wide sum to OUT_W bits.
// Purely combinational so the layer output stage can reuse it directly.
module fcc_sat_relu
   import fcc_pkg::*;
#(
   parameter int ACC_W = 20,
   parameter int OUT_W = 16
) (
   input  logic signed [ACC_W-1:0] sum,
   input  logic                    relu_en,
   output logic signed [OUT_W-1:0] result,
   output logic                    sat
);

   localparam logic signed [ACC_W-1:0] MAX_EXT = ACC_W'(sat_max(OUT_W));
   localparam logic signed [ACC_W-1:0] MIN_EXT = ACC_W'(sat_min(OUT_W));
   localparam logic signed [OUT_W-1:0] MAX_OUT = OUT_W'(sat_max(OUT_W));
   localparam logic signed [OUT_W-1:0] MIN_OUT = OUT_W'(sat_min(OUT_W));

   always_comb begin
      result = sum[OUT_W-1:0];
      sat    = 1'b0;
      // ReLU wins over negative saturation: a clamped-to-zero result is never flagged.
      if (relu_en && (sum < 0)) begin
         result = '0;
      end else if (sum > MAX_EXT) begin
         result = MAX_OUT;
         sat    = 1'b1;
      end else if (sum < MIN_EXT) begin
         result = MIN_OUT;
         sat    = 1'b1;
      end
   end

endmodule

// File: rtl/fcc_mac_neuron.sv
// Sequential MAC neuron: accumulates node*weight over a vector, adds the bias
// captured on the first beat, then applies optional ReLU and saturation.
module fcc_mac_neuron
   import fcc_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int N_IN    = 16,
   parameter int ACC_W   = 20,
   parameter int OUT_W   = 16,
   parameter int RELU_EN = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   fcc_mac_neuron_if.slave  bus
);

   localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

   fcc_state_e state_q, state_d;

   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic signed [DATA_W-1:0] bias_q, bias_d;
   logic                     len_err_q, len_err_d;

   logic                     out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0]  out_data_q, out_data_d;
   logic                     out_sat_q, out_sat_d;
   logic                     out_len_err_q, out_len_err_d;

   logic                       in_ready;
   logic                       beat_fire;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    sum;
   logic signed [OUT_W-1:0]    sat_result;
   logic                       sat_flag;

   assign in_ready  = (state_q == ACC);
   assign beat_fire = bus.in_valid && in_ready;
   assign prod      = bus.in_node * bus.in_wegt;
   assign sum       = acc_q + ACC_W'(bias_q);

   fcc_sat_relu #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
   ) u_sat_relu (
      .sum     (sum),
      .relu_en (RELU_EN != 0),
      .result  (sat_result),
      .sat     (sat_flag)
   );

   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      bias_d        = bias_q;
      len_err_d     = len_err_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_sat_d     = out_sat_q;
      out_len_err_d = out_len_err_q;

      unique case (state_q)
         ACC: begin
            if (beat_fire) begin
               acc_d = acc_q + ACC_W'(prod);
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == '0) begin
                  bias_d = bus.in_bias;
               end
               // A vector closes on the N_IN-th beat or on an early in_last.
               if ((cnt_q == CNT_LAST) || bus.in_last) begin
                  len_err_d = (cnt_q != CNT_LAST) || !bus.in_last;
                  state_d   = FIN;
               end
            end
         end
         FIN: begin
            out_data_d    = sat_result;
            out_sat_d     = sat_flag;
            out_len_err_d = len_err_q;
            out_valid_d   = 1'b1;
            state_d       = OUT;
         end
         OUT: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
               acc_d       = '0;
               cnt_d       = '0;
               state_d     = ACC;
            end
         end
         default: begin
            state_d = ACC;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ACC;
         acc_q         <= '0;
         cnt_q         <= '0;
         bias_q        <= '0;
         len_err_q     <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_sat_q     <= 1'b0;
         out_len_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         bias_q        <= bias_d;
         len_err_q     <= len_err_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_sat_q     <= out_sat_d;
         out_len_err_q <= out_len_err_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.out_sat     = out_sat_q;
   assign bus.out_len_err = out_len_err_q;

endmodule

// File: tb/tb_fcc_mac_neuron.sv
// Directed bench for fcc_mac_neuron: three lanes (N_IN=4, N_IN=16, N_IN=4 with ReLU)
// checked every output cycle against an arithmetic model plus literal expectations.
module tb_fcc_mac_neuron;

   localparam int LANES = 3;
   localparam int NIN_T  [LANES] = '{4, 16, 4};
   localparam int RELU_T [LANES] = '{0, 0, 1};

   typedef struct packed {
      logic signed [15:0] d;
      logic               s;
      logic               e;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic tb_valid [LANES];
   logic tb_last  [LANES];
   logic tb_ready [LANES];
   logic signed [7:0] tb_node [LANES];
   logic signed [7:0] tb_wegt [LANES];
   logic signed [7:0] tb_bias [LANES];

   logic rdy     [LANES];
   logic o_valid [LANES];
   logic o_sat   [LANES];
   logic o_len   [LANES];
   logic signed [15:0] o_data [LANES];

   int   n_vec = 0;
   int   n_bad = 0;
   int   vn [16];
   int   vw [16];
   res_t exp_q [LANES][$];
   res_t cmp_e;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      fcc_mac_neuron_if #(.DATA_W(8), .OUT_W(16)) bus ();

      assign bus.in_valid  = tb_valid[gi];
      assign bus.in_node   = tb_node[gi];
      assign bus.in_wegt   = tb_wegt[gi];
      assign bus.in_bias   = tb_bias[gi];
      assign bus.in_last   = tb_last[gi];
      assign bus.out_ready = tb_ready[gi];
      assign rdy[gi]       = bus.in_ready;
      assign o_valid[gi]   = bus.out_valid;
      assign o_data[gi]    = bus.out_data;
      assign o_sat[gi]     = bus.out_sat;
      assign o_len[gi]     = bus.out_len_err;

      fcc_mac_neuron #(
         .DATA_W  (8),
         .N_IN    (NIN_T[gi]),
         .ACC_W   (20),
         .OUT_W   (16),
         .RELU_EN (RELU_T[gi])
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   // Expected result of a vector of len beats taken from vn/vw.
   function automatic res_t model(int l, int len, bit last, int bias);
      longint s;
      res_t   r;
      s = bias;
      for (int i = 0; i < len; i++) s += longint'(vn[i] * vw[i]);
      r.e = (len != NIN_T[l]) || !last;
      r.s = 1'b0;
      if (RELU_T[l] != 0 && s < 0) begin
         r.d = '0;
      end else if (s > 32767) begin
         r.d = 16'sd32767;
         r.s = 1'b1;
      end else if (s < -32768) begin
         r.d = -16'sd32768;
         r.s = 1'b1;
      end else begin
         r.d = 16'(s);
      end
      return r;
   endfunction

   task automatic check1(string nm, int got, int want);
      n_vec++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   task automatic beat(int l, int node, int w, int b, bit last);
      int t;
      t = 0;
      @(negedge clk);
      while (!rdy[l] && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!rdy[l]) begin
         n_vec++;
         n_bad++;
         $display("FAIL beat_timeout lane%0d: in_ready 0 after %0d cycles, want 1", l, t);
      end
      tb_valid[l] = 1'b1;
      tb_node[l]  = 8'(node);
      tb_wegt[l]  = 8'(w);
      tb_bias[l]  = 8'(b);
      tb_last[l]  = last;
      @(posedge clk);
      #1;
      tb_valid[l] = 1'b0;
      tb_last[l]  = 1'b0;
   endtask

   // Bias differs on every beat after the first, so only the first one may be captured.
   task automatic send_vec(int l, int len, bit last, int bias);
      exp_q[l].push_back(model(l, len, last, bias));
      for (int i = 0; i < len; i++) begin
         beat(l, vn[i], vw[i], (i == 0) ? bias : bias + 13, last && (i == len - 1));
      end
   endtask

   task automatic wait_out(int l, int d, int s, int e, string nm);
      int t;
      t = 0;
      @(negedge clk);
      while (!o_valid[l] && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!o_valid[l]) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s timeout: out_valid 0 after %0d cycles, want 1", nm, t);
      end else begin
         check1({nm, ".data"}, int'(o_data[l]), d);
         check1({nm, ".sat"},  int'(o_sat[l]), s);
         check1({nm, ".len"},  int'(o_len[l]), e);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         for (int l = 0; l < LANES; l++) begin
            if (o_valid[l]) begin
               n_vec++;
               if (exp_q[l].size() == 0) begin
                  n_bad++;
                  $display("FAIL model lane%0d: out_valid=1 data=%0d, want no result pending",
                           l, o_data[l]);
               end else begin
                  cmp_e = exp_q[l][0];
                  if (o_data[l] != cmp_e.d || o_sat[l] != cmp_e.s || o_len[l] != cmp_e.e) begin
                     n_bad++;
                     $display("FAIL model lane%0d: got data=%0d sat=%0d len=%0d, want data=%0d sat=%0d len=%0d",
                              l, o_data[l], o_sat[l], o_len[l], cmp_e.d, cmp_e.s, cmp_e.e);
                  end
                  if (tb_ready[l]) void'(exp_q[l].pop_front());
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         tb_valid[l] = 1'b0;
         tb_last[l]  = 1'b0;
         tb_ready[l] = 1'b1;
         tb_node[l]  = '0;
         tb_wegt[l]  = '0;
         tb_bias[l]  = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int l = 0; l < LANES; l++) begin
         check1($sformatf("rst.valid%0d", l), int'(o_valid[l]), 0);
         check1($sformatf("rst.data%0d", l),  int'(o_data[l]), 0);
         check1($sformatf("rst.sat%0d", l),   int'(o_sat[l]), 0);
         check1($sformatf("rst.len%0d", l),   int'(o_len[l]), 0);
         check1($sformatf("rst.ready%0d", l), int'(rdy[l]), 1);
      end
      rst_n = 1'b1;

      // 1+2+3+4 + 5, and latency from the last beat's edge.
      for (int i = 0; i < 4; i++) begin vn[i] = i + 1; vw[i] = 1; end
      send_vec(0, 4, 1'b1, 5);
      check1("lat.edge_k", int'(o_valid[0]), 0);
      @(posedge clk);
      #1;
      check1("lat.edge_k1", int'(o_valid[0]), 1);
      wait_out(0, 15, 0, 0, "sum15");

      for (int i = 0; i < 16; i++) begin vn[i] = -128; vw[i] = -128; end
      send_vec(1, 16, 1'b1, 127);
      wait_out(1, 32767, 1, 0, "satpos");

      for (int i = 0; i < 4; i++) begin vn[i] = 10; vw[i] = -3; end
      send_vec(2, 4, 1'b1, 0);
      wait_out(2, 0, 0, 0, "relu");
      send_vec(0, 4, 1'b1, 0);
      wait_out(0, -120, 0, 0, "norelu");

      vn[0] = 2; vn[1] = 3; vw[0] = 4; vw[1] = 5;
      send_vec(0, 2, 1'b1, -1);
      wait_out(0, 22, 0, 1, "early_last");
      for (int i = 0; i < 4; i++) begin vn[i] = i + 1; vw[i] = 1; end
      send_vec(0, 4, 1'b1, 5);
      wait_out(0, 15, 0, 0, "after_early");

      for (int i = 0; i < 4; i++) begin vn[i] = -128; vw[i] = 127; end
      send_vec(0, 4, 1'b1, -128);
      wait_out(0, -32768, 1, 0, "satneg");

      for (int i = 0; i < 16; i++) begin vn[i] = i; vw[i] = 1; end
      send_vec(1, 16, 1'b0, 0);
      wait_out(1, 120, 0, 1, "no_last");

      for (int i = 0; i < 4; i++) begin vn[i] = 3; vw[i] = 4; end
      send_vec(2, 4, 1'b1, 2);
      wait_out(2, 50, 0, 0, "relu_pos");

      // Backpressure: result held, input refused, junk beats offered meanwhile.
      @(posedge clk);
      #1;
      tb_ready[0] = 1'b0;
      vn[0] = 5; vn[1] = 6; vn[2] = 7; vn[3] = 8;
      vw[0] = 2; vw[1] = -1; vw[2] = 3; vw[3] = 1;
      send_vec(0, 4, 1'b1, -7);
      @(posedge clk);
      #1;
      check1("bp.valid", int'(o_valid[0]), 1);
      for (int c = 0; c < 5; c++) begin
         tb_valid[0] = 1'b1;
         tb_node[0]  = 8'sd100;
         tb_wegt[0]  = 8'sd100;
         tb_bias[0]  = 8'sd50;
         check1($sformatf("bp.ready%0d", c), int'(rdy[0]), 0);
         check1($sformatf("bp.data%0d", c), int'(o_data[0]), 26);
         @(posedge clk);
         #1;
      end
      tb_valid[0] = 1'b0;
      check1("bp.hold_valid", int'(o_valid[0]), 1);
      tb_ready[0] = 1'b1;
      check1("bp.ready_out", int'(rdy[0]), 0);
      @(posedge clk);
      #1;
      check1("bp.released", int'(o_valid[0]), 0);
      check1("bp.ready_next", int'(rdy[0]), 1);
      for (int i = 0; i < 4; i++) begin vn[i] = 4 - i; vw[i] = 1; end
      send_vec(0, 4, 1'b1, 0);
      wait_out(0, 10, 0, 0, "after_bp");

      // Reset mid-vector discards the partial sum.
      beat(0, 7, 7, 3, 1'b0);
      beat(0, 7, 7, 3, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check1("midrst.valid", int'(o_valid[0]), 0);
      check1("midrst.ready", int'(rdy[0]), 1);
      for (int i = 0; i < 4; i++) begin vn[i] = 1; vw[i] = 1; end
      send_vec(0, 4, 1'b1, 0);
      wait_out(0, 4, 0, 0, "midrst");

      repeat (3) @(posedge clk);
      #1;
      for (int l = 0; l < LANES; l++) begin
         check1($sformatf("drain%0d", l), exp_q[l].size(), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
